// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Macro CONSOLE_SCROLL_EN: when defined, the FSM enum carries the scroll
// read/write states; when undefined they do not exist.
package console_pkg;

    localparam int COL_BITS = 7;
    localparam int ROW_BITS = 5;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

`ifdef CONSOLE_SCROLL_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        SCROLL_RD = 3'd2,
        SCROLL_WR = 3'd3,
        CLEAR     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        CLEAR     = 3'd4
    } state_t;
`endif

    // Cursor operation requested by the FSM for the current character.
    typedef enum logic [1:0] {
        OP_NONE      = 2'd0,
        OP_ADVANCE   = 2'd1,
        OP_NEWLINE   = 2'd2,
        OP_BACKSPACE = 2'd3
    } cur_op_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor row/col registers with advance, newline and backspace stepping.
// Latency: next position is combinational from op; registers update on op_en.
// Backpressure: none; the FSM applies at most one op per WRITE cycle.
//
// Ports: op/op_en select the step; row/col are the current cursor;
// next_row/next_col the stepped position (also the backspace write target);
// bs_ok is high when a backspace actually moves; wrap flags a row increment
// from the bottom row. Macro CONSOLE_SCROLL_EN selects where a wrap lands.
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_en,
    input  logic [1:0]          op,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] col,
    output logic [ROW_BITS-1:0] next_row,
    output logic [COL_BITS-1:0] next_col,
    output logic                bs_ok,
    output logic                wrap
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
`ifdef CONSOLE_SCROLL_EN
    // The screen scrolls under the cursor, so it stays on the bottom row.
    localparam logic [ROW_BITS-1:0] WRAP_ROW = LAST_ROW;
`else
    // No scroll: the cursor jumps to the top and row 0 is cleared.
    localparam logic [ROW_BITS-1:0] WRAP_ROW = '0;
`endif

    logic row_inc;

    always_comb begin
        next_row = row;
        next_col = col;
        bs_ok    = 1'b0;
        wrap     = 1'b0;
        row_inc  = 1'b0;
        case (op)
            OP_ADVANCE: begin
                if (col == LAST_COL) begin
                    next_col = '0;
                    row_inc  = 1'b1;
                end else begin
                    next_col = col + COL_BITS'(1);
                end
            end
            OP_NEWLINE: begin
                next_col = '0;
                row_inc  = 1'b1;
            end
            OP_BACKSPACE: begin
                if (col != '0) begin
                    next_col = col - COL_BITS'(1);
                    bs_ok    = 1'b1;
                end else if (row != '0) begin
                    next_row = row - ROW_BITS'(1);
                    next_col = LAST_COL;
                    bs_ok    = 1'b1;
                end
            end
            default: ;
        endcase
        if (row_inc) begin
            if (row == LAST_ROW) begin
                wrap     = 1'b1;
                next_row = WRAP_ROW;
            end else begin
                next_row = row + ROW_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (op_en) begin
            row <= next_row;
            col <= next_col;
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Character stream to text video RAM writer with cursor, wrap, backspace, scroll.
// Latency: accept at t, RAM write at t+1, ready again at t+2; scroll/clear add busy cycles.
// Backpressure: in_ready is high only in IDLE; low during WRITE, scroll and clear.
//
// Ports: in_valid/in_ascii/in_ready character handshake; mem_addr/mem_wdata/
// mem_we/mem_rdata drive a synchronous video RAM (addr = {row, col});
// cursor_addr feeds the renderer's cursor overlay; busy marks scroll/clear.
// Macro CONSOLE_SCROLL_EN: defined = scroll up on bottom wrap; undefined =
// wrap to the top and clear row 0.
module text_console_writer
    import console_pkg::*;
#(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_ascii,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
`ifdef CONSOLE_SCROLL_EN
    localparam logic [ROW_BITS-1:0] LAST_ROW  = ROW_BITS'(ROWS - 1);
    localparam logic [ROW_BITS-1:0] CLEAR_ROW = LAST_ROW;
`else
    localparam logic [ROW_BITS-1:0] CLEAR_ROW = '0;
`endif

    function automatic logic [ADDR_W-1:0] rc_addr(input logic [ROW_BITS-1:0] r,
                                                   input logic [COL_BITS-1:0] c);
        return ADDR_W'({r, c});
    endfunction

    state_t                state, state_n;
    logic [7:0]            char_q;
    logic [COL_BITS-1:0]   scan_col, scan_col_n;
`ifdef CONSOLE_SCROLL_EN
    logic [ROW_BITS-1:0]   scan_row, scan_row_n;
`else
    logic                  unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    logic [1:0]            op;
    logic                  op_en;
    logic [ROW_BITS-1:0]   cur_row, nxt_row;
    logic [COL_BITS-1:0]   cur_col, nxt_col;
    logic                  bs_ok, wrap;

    // Character class decode; only consumed while in WRITE.
    always_comb begin
        op = OP_NONE;
        if (is_printable(char_q)) begin
            op = OP_ADVANCE;
        end else if ((char_q == CH_LF) || (char_q == CH_CR)) begin
            op = OP_NEWLINE;
        end else if (char_q == CH_BS) begin
            op = OP_BACKSPACE;
        end
    end

    assign op_en = (state == WRITE);

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .op_en    (op_en),
        .op       (op),
        .row      (cur_row),
        .col      (cur_col),
        .next_row (nxt_row),
        .next_col (nxt_col),
        .bs_ok    (bs_ok),
        .wrap     (wrap)
    );

    assign cursor_addr = rc_addr(cur_row, cur_col);
    // Reset gates ready directly so no character is taken while it is held.
    assign in_ready    = (state == IDLE) && !reset;

    always_comb begin
        state_n    = state;
        scan_col_n = scan_col;
`ifdef CONSOLE_SCROLL_EN
        scan_row_n = scan_row;
`endif
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) state_n = WRITE;
            end
            WRITE: begin
                if (op == OP_ADVANCE) begin
                    mem_we    = 1'b1;
                    mem_addr  = cursor_addr;
                    mem_wdata = char_q;
                end else if ((op == OP_BACKSPACE) && bs_ok) begin
                    // Backspace erases the cell it steps back onto.
                    mem_we    = 1'b1;
                    mem_addr  = rc_addr(nxt_row, nxt_col);
                    mem_wdata = CH_SPACE;
                end
                scan_col_n = '0;
                if (wrap) begin
`ifdef CONSOLE_SCROLL_EN
                    scan_row_n = ROW_BITS'(1);
                    state_n    = SCROLL_RD;
`else
                    state_n    = CLEAR;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
`ifdef CONSOLE_SCROLL_EN
            SCROLL_RD: begin
                busy     = 1'b1;
                mem_addr = rc_addr(scan_row, scan_col);
                state_n  = SCROLL_WR;
            end
            SCROLL_WR: begin
                // mem_rdata holds the cell addressed in the previous SCROLL_RD.
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = rc_addr(scan_row - ROW_BITS'(1), scan_col);
                mem_wdata = mem_rdata;
                if (scan_col == LAST_COL) begin
                    scan_col_n = '0;
                    if (scan_row == LAST_ROW) begin
                        state_n = CLEAR;
                    end else begin
                        scan_row_n = scan_row + ROW_BITS'(1);
                        state_n    = SCROLL_RD;
                    end
                end else begin
                    scan_col_n = scan_col + COL_BITS'(1);
                    state_n    = SCROLL_RD;
                end
            end
`endif
            CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = rc_addr(CLEAR_ROW, scan_col);
                mem_wdata = CH_SPACE;
                if (scan_col == LAST_COL) begin
                    scan_col_n = '0;
                    state_n    = IDLE;
                end else begin
                    scan_col_n = scan_col + COL_BITS'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            char_q   <= '0;
            scan_col <= '0;
`ifdef CONSOLE_SCROLL_EN
            scan_row <= '0;
`endif
        end else begin
            state    <= state_n;
            scan_col <= scan_col_n;
`ifdef CONSOLE_SCROLL_EN
            scan_row <= scan_row_n;
`endif
            if (in_valid && in_ready) char_q <= in_ascii;
        end
    end

endmodule
